// File: rtl/skid_register.sv
// Two-entry skid register for a valid/ready stream.
// The main entry drives out_data directly; the skid entry absorbs the one
// beat that arrives while the consumer stalls, so in_ready can be decoded
// from registered state alone and no combinational ready path crosses the
// block. A three-state machine (EMPTY / ONE / FULL) tracks occupancy.
module skid_register #(
  parameter int unsigned          width     = 16,
  parameter logic [width-1:0]     reset_val = '0
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [width-1:0]   main_q,  main_d;
  logic [width-1:0]   skid_q,  skid_d;

  logic               in_xfer;
  logic               out_xfer;

  // Handshake qualifiers: a transfer happens only when both sides agree.
  assign in_xfer  = in_valid  & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Head entry is presented straight from the main register.
  assign out_data = main_q;

  // State register: occupancy, cleared asynchronously on reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush wins over every transfer.
  // NOTE: the default assignment first guarantees every path drives
  // state_d, so no latch is inferred when a branch omits it.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_xfer) state_d = ST_ONE;
        ST_ONE: begin
          if (in_xfer && !out_xfer)      state_d = ST_FULL;
          else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_xfer) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output decode: ready/valid/count depend on the registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    count     = 2'd0;
    unique case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        count     = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        count     = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
      end
    endcase
  end

  // Datapath next values: entries change only on transfers, never on flush,
  // so a flushed block keeps its stale payload with valid cleared.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      unique case (state_q)
        ST_EMPTY: if (in_xfer) main_d = in_data;
        ST_ONE: begin
          if (in_xfer && out_xfer) main_d = in_data;
          else if (in_xfer)        skid_d = in_data;
        end
        ST_FULL:  if (out_xfer) main_d = skid_q;
        default:  ;
      endcase
    end
  end

  // Payload registers: both entries load reset_val on reset.
  // NOTE: these two words are reset deliberately so out_data shows a known
  // value out of reset; a deeper storage array would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= reset_val;
      skid_q <= reset_val;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_register.sv
// Directed bench for skid_register (width 16, reset_val 0).
// Inputs change 1 ns after each rising edge; outputs are checked there too,
// showing the state produced by that edge.
module tb_skid_register;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;

  skid_register #(
    .width     (W),
    .reset_val (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'h0000);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Back-to-back stream with consumer always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      tick();
      check("stream_data",     32'(out_data),  32'(i));
      check("stream_valid",    32'(out_valid), 32'd1);
      check("stream_count",    32'(count),     32'd1);
      check("stream_in_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_count", 32'(count),     32'd0);
    check("stream_drain_valid", 32'(out_valid), 32'd0);

    // Stall hold: single entry, consumer stalled for 5 cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0042;
    tick();
    in_valid  = 1'b0;
    in_data   = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data",  32'(out_data),  32'h0042);
      check("hold_valid", 32'(out_valid), 32'd1);
    end

    // Simultaneous push and pop in ONE.
    in_valid  = 1'b1;
    in_data   = 16'h0007;
    out_ready = 1'b1;
    tick();
    check("pushpop_count", 32'(count),    32'd1);
    check("pushpop_data",  32'(out_data), 32'h0007);
    in_valid = 1'b0;
    tick();
    check("pushpop_drain", 32'(count), 32'd0);

    // Fill to FULL, offer a third beat, then release the consumer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hAAAA;
    tick();
    in_data   = 16'hBBBB;
    tick();
    check("full_count",    32'(count),    32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head",     32'(out_data), 32'hAAAA);
    in_data   = 16'hCCCC;
    tick();
    check("full_ignore_count", 32'(count),    32'd2);
    check("full_ignore_head",  32'(out_data), 32'hAAAA);
    out_ready = 1'b1;
    tick();
    check("drain1_data",     32'(out_data), 32'hBBBB);
    check("drain1_count",    32'(count),    32'd1);
    check("drain1_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("drain2_data",  32'(out_data),  32'hCCCC);
    check("drain2_count", 32'(count),     32'd1);
    check("drain2_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain3_count", 32'(count), 32'd0);

    // Flush from FULL with same-cycle push and pop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    tick();
    in_data   = 16'h5678;
    tick();
    check("preflush_count", 32'(count), 32'd2);
    flush     = 1'b1;
    in_data   = 16'hDDDD;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count",    32'(count),     32'd0);
    check("flush_valid",    32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready),  32'd1);
    check("flush_data_held", 32'(out_data), 32'h1234);
    tick();
    check("postflush_data",  32'(out_data),  32'h1234);
    check("postflush_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    tick();
    in_data   = 16'h2222;
    tick();
    in_valid  = 1'b0;
    check("prereset_count", 32'(count),    32'd2);
    check("prereset_head",  32'(out_data), 32'h1111);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid",    32'(out_valid), 32'd0);
    check("async_count",    32'(count),     32'd0);
    check("async_in_ready", 32'(in_ready),  32'd1);
    check("async_data",     32'(out_data),  32'h0000);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3333;
    tick();
    in_valid = 1'b0;
    check("postreset_data",  32'(out_data),  32'h3333);
    check("postreset_valid", 32'(out_valid), 32'd1);
    check("postreset_count", 32'(count),     32'd1);
    // Skid was cleared by reset: a pop from ONE must empty the block.
    out_ready = 1'b1;
    tick();
    check("postreset_pop_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
